// File: rtl/rv_pkg.sv
// Shared pipeline-control types for the hazard controller.
// Contents: forwarding select encoding, per-stage control bundle, bubble constant,
//           and a helper that resolves one forwarding select.
package rv_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // Control bundle carried down ID/EX -> EX/MEM -> MEM/WB.
  typedef struct packed {
    logic       reg_write;
    logic       load;
    logic       store;
    logic       branch;
    logic [1:0] next_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use_rs1;
    logic       use_rs2;
  } pipe_ctrl_t;

  // A bubble is all-zero: it never writes, loads, stores or branches.
  localparam pipe_ctrl_t PIPE_BUBBLE = '0;

  // Pick the operand source for one EX source register. The MEM stage wins over
  // WB because it holds the younger result. A load in MEM has no data yet, so
  // it is never a forwarding source (the load-use stall covers that case).
  function automatic fwd_sel_t fwd_pick(
    input logic       use_src,
    input logic [4:0] src,
    input pipe_ctrl_t mem,
    input pipe_ctrl_t wb
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_src && (src != 5'd0)) begin
      if (mem.reg_write && !mem.load && (mem.rd == src)) begin
        sel = FWD_MEM;
      end else if (wb.reg_write && (wb.rd == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control stage register holding a pipe_ctrl_t bundle.
// Ports: clk/rst (sync, active-high), bubble_i forces a bubble at the next edge,
//        d_i is the incoming bundle, q_o the registered bundle.
module ctrl_stage_reg
  import rv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bubble_i,
  input  pipe_ctrl_t d_i,
  output pipe_ctrl_t q_o
);

  pipe_ctrl_t stage_q;

  always_ff @(posedge clk) begin
    if (rst || bubble_i) begin
      stage_q <= PIPE_BUBBLE;
    end else begin
      stage_q <= d_i;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall, redirect flush,
// EX operand forwarding select, and saturating stall/flush event counters.
// Ports: ID decode inputs (id_*), ex_redirect; stall/flush/fwd outputs are
//        combinational, per-stage control outputs (ex_*, mem_*, wb_*) and the
//        16-bit counters are registered.
module pipe_hazard_ctrl
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_reg_write,
  input  logic        id_load,
  input  logic        id_store,
  input  logic        id_branch,
  input  logic [1:0]  id_next_sel,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_redirect,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        ex_reg_write,
  output logic        ex_load,
  output logic        ex_store,
  output logic        ex_branch,
  output logic [1:0]  ex_next_sel,
  output logic [4:0]  ex_rd,
  output logic [4:0]  mem_rd,
  output logic [4:0]  wb_rd,
  output logic        mem_reg_write,
  output logic        mem_load,
  output logic        mem_store,
  output logic        wb_reg_write,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  pipe_ctrl_t id_ctrl;
  pipe_ctrl_t idex_q;
  pipe_ctrl_t exmem_q;
  pipe_ctrl_t memwb_q;

  logic       load_use;
  logic       idex_bubble;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    id_ctrl           = PIPE_BUBBLE;
    id_ctrl.reg_write = id_reg_write;
    id_ctrl.load      = id_load;
    id_ctrl.store     = id_store;
    id_ctrl.branch    = id_branch;
    id_ctrl.next_sel  = id_next_sel;
    id_ctrl.rs1       = id_rs1;
    id_ctrl.rs2       = id_rs2;
    id_ctrl.rd        = id_rd;
    id_ctrl.use_rs1   = id_use_rs1;
    id_ctrl.use_rs2   = id_use_rs2;
  end

  // Load in EX whose result the ID instruction needs; x0 is never a hazard.
  assign load_use = !rst && idex_q.load && (idex_q.rd != 5'd0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == idex_q.rd)) ||
                     (id_use_rs2 && (id_rs2 == idex_q.rd)));

  // Redirect wins over load-use: the ID instruction is discarded anyway, so
  // holding the front end for it would only waste a cycle.
  assign flush_if_id = !rst && ex_redirect;
  assign stall_pc    = load_use && !ex_redirect;
  assign stall_if_id = stall_pc;

  assign idex_bubble = flush_if_id || stall_pc || !id_valid;

  // EX/MEM and MEM/WB never hold: a stall only injects a bubble at ID/EX.
  ctrl_stage_reg u_idex (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (idex_bubble),
    .d_i      (id_ctrl),
    .q_o      (idex_q)
  );

  ctrl_stage_reg u_exmem (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (1'b0),
    .d_i      (idex_q),
    .q_o      (exmem_q)
  );

  ctrl_stage_reg u_memwb (
    .clk      (clk),
    .rst      (rst),
    .bubble_i (1'b0),
    .d_i      (exmem_q),
    .q_o      (memwb_q)
  );

  // Forwarding selects are forced to the register file while in reset.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      fwd_a = fwd_pick(idex_q.use_rs1, idex_q.rs1, exmem_q, memwb_q);
      fwd_b = fwd_pick(idex_q.use_rs2, idex_q.rs2, exmem_q, memwb_q);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_pc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_if_id && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

  assign ex_reg_write  = idex_q.reg_write;
  assign ex_load       = idex_q.load;
  assign ex_store      = idex_q.store;
  assign ex_branch     = idex_q.branch;
  assign ex_next_sel   = idex_q.next_sel;
  assign ex_rd         = idex_q.rd;

  assign mem_reg_write = exmem_q.reg_write;
  assign mem_load      = exmem_q.load;
  assign mem_store     = exmem_q.store;
  assign mem_rd        = exmem_q.rd;

  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_rd         = memwb_q.rd;

  // Later-stage fields not needed here still travel with the bundle.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{exmem_q, memwb_q};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Drives ID decode vectors cycle by cycle and checks stall/flush/forward and
// stage outputs against hand-computed values.
module tb_pipe_hazard_ctrl;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_reg_write, id_load, id_store, id_branch;
  logic [1:0]  id_next_sel;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_redirect;
  logic        stall_pc, stall_if_id, flush_if_id;
  logic        ex_reg_write, ex_load, ex_store, ex_branch;
  logic [1:0]  ex_next_sel;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        mem_reg_write, mem_load, mem_store, wb_reg_write;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_reg_write  (id_reg_write),
    .id_load       (id_load),
    .id_store      (id_store),
    .id_branch     (id_branch),
    .id_next_sel   (id_next_sel),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_redirect   (ex_redirect),
    .stall_pc      (stall_pc),
    .stall_if_id   (stall_if_id),
    .flush_if_id   (flush_if_id),
    .ex_reg_write  (ex_reg_write),
    .ex_load       (ex_load),
    .ex_store      (ex_store),
    .ex_branch     (ex_branch),
    .ex_next_sel   (ex_next_sel),
    .ex_rd         (ex_rd),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .mem_reg_write (mem_reg_write),
    .mem_load      (mem_load),
    .mem_store     (mem_store),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pipe_ctrl_t ins(input logic rw, input logic ld, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic u1, input logic u2);
    pipe_ctrl_t c;
    c           = '0;
    c.reg_write = rw;
    c.load      = ld;
    c.rd        = rd;
    c.rs1       = rs1;
    c.rs2       = rs2;
    c.use_rs1   = u1;
    c.use_rs2   = u2;
    return c;
  endfunction

  task automatic apply(input logic v, input pipe_ctrl_t c);
    id_valid     = v;
    id_reg_write = c.reg_write;
    id_load      = c.load;
    id_store     = c.store;
    id_branch    = c.branch;
    id_next_sel  = c.next_sel;
    id_rs1       = c.rs1;
    id_rs2       = c.rs2;
    id_rd        = c.rd;
    id_use_rs1   = c.use_rs1;
    id_use_rs2   = c.use_rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  pipe_ctrl_t br;

  initial begin
    // Reset with a hazard-looking ID and a redirect: all control must read 0.
    rst = 1'b1;
    ex_redirect = 1'b1;
    apply(1'b1, ins(1, 1, 5'd5, 5'd5, 5'd5, 1, 1));
    tick();
    tick();
    chk("rst_stall_pc", {15'd0, stall_pc}, 16'd0);
    chk("rst_flush", {15'd0, flush_if_id}, 16'd0);
    chk("rst_fwd_a", {14'd0, fwd_a}, 16'd0);
    chk("rst_ex_load", {15'd0, ex_load}, 16'd0);
    chk("rst_wb_rw", {15'd0, wb_reg_write}, 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_flush_cnt", flush_cnt, 16'd0);

    // Load-use: lw x5 then add x6,x5,x1.
    rst = 1'b0;
    ex_redirect = 1'b0;
    apply(1'b1, ins(1, 1, 5'd5, 5'd2, 5'd0, 1, 0));
    tick();
    chk("lw_ex_load", {15'd0, ex_load}, 16'd1);
    chk("lw_ex_rd", {11'd0, ex_rd}, 16'd5);
    apply(1'b1, ins(1, 0, 5'd6, 5'd5, 5'd1, 1, 1));
    #1;
    chk("lu_stall_pc", {15'd0, stall_pc}, 16'd1);
    chk("lu_stall_if_id", {15'd0, stall_if_id}, 16'd1);
    chk("lu_flush", {15'd0, flush_if_id}, 16'd0);
    tick();
    chk("lu_bubble_rw", {15'd0, ex_reg_write}, 16'd0);
    chk("lu_bubble_rd", {11'd0, ex_rd}, 16'd0);
    chk("lu_mem_load", {15'd0, mem_load}, 16'd1);
    chk("lu_mem_rd", {11'd0, mem_rd}, 16'd5);
    chk("lu_stall_cnt", stall_cnt, 16'd1);
    chk("lu_one_cycle", {15'd0, stall_pc}, 16'd0);
    tick();
    chk("lu_ex_rd", {11'd0, ex_rd}, 16'd6);
    chk("lu_fwd_a_wb", {14'd0, fwd_a}, 16'd2);
    chk("lu_fwd_b_rf", {14'd0, fwd_b}, 16'd0);
    chk("lu_wb_rd", {11'd0, wb_rd}, 16'd5);
    chk("lu_stall_cnt_hold", stall_cnt, 16'd1);

    // EX/MEM forward on rs2, then the same pattern through x0.
    apply(1'b1, ins(1, 0, 5'd7, 5'd3, 5'd4, 1, 1));
    tick();
    apply(1'b1, ins(1, 0, 5'd8, 5'd1, 5'd7, 1, 1));
    tick();
    chk("mem_fwd_b", {14'd0, fwd_b}, 16'd1);
    chk("mem_fwd_a_none", {14'd0, fwd_a}, 16'd0);
    apply(1'b1, ins(1, 0, 5'd0, 5'd3, 5'd4, 1, 1));
    tick();
    apply(1'b1, ins(1, 0, 5'd12, 5'd0, 5'd0, 1, 1));
    tick();
    chk("x0_mem_rw", {15'd0, mem_reg_write}, 16'd1);
    chk("x0_fwd_b", {14'd0, fwd_b}, 16'd0);
    chk("x0_fwd_a", {14'd0, fwd_a}, 16'd0);

    // Double hazard on x9: MEM has priority.
    apply(1'b1, ins(1, 0, 5'd9, 5'd1, 5'd2, 1, 1));
    tick();
    tick();
    apply(1'b1, ins(1, 0, 5'd10, 5'd9, 5'd9, 1, 1));
    tick();
    chk("dbl_fwd_a", {14'd0, fwd_a}, 16'd1);
    chk("dbl_fwd_b", {14'd0, fwd_b}, 16'd1);

    // WB-only forward on rs2; rs1 matches but is not used.
    apply(1'b1, ins(1, 0, 5'd11, 5'd1, 5'd2, 1, 1));
    tick();
    apply(1'b1, ins(0, 0, 5'd0, 5'd0, 5'd0, 0, 0));
    tick();
    apply(1'b1, ins(1, 0, 5'd13, 5'd11, 5'd11, 0, 1));
    tick();
    chk("wb_fwd_b", {14'd0, fwd_b}, 16'd2);
    chk("unused_rs1_fwd_a", {14'd0, fwd_a}, 16'd0);

    // id_valid=0 loads a bubble.
    apply(1'b0, ins(1, 0, 5'd12, 5'd1, 5'd2, 1, 1));
    tick();
    chk("inv_ex_rw", {15'd0, ex_reg_write}, 16'd0);
    chk("inv_ex_rd", {11'd0, ex_rd}, 16'd0);

    // Store/branch/next_sel travel through the stages.
    br = ins(0, 0, 5'd0, 5'd1, 5'd2, 1, 1);
    br.store = 1'b1;
    br.branch = 1'b1;
    br.next_sel = 2'b11;
    apply(1'b1, br);
    tick();
    chk("br_ex_store", {15'd0, ex_store}, 16'd1);
    chk("br_ex_branch", {15'd0, ex_branch}, 16'd1);
    chk("br_ex_next_sel", {14'd0, ex_next_sel}, 16'd3);
    apply(1'b0, ins(0, 0, 5'd0, 5'd0, 5'd0, 0, 0));
    tick();
    chk("br_mem_store", {15'd0, mem_store}, 16'd1);

    // Redirect and load-use together: flush wins.
    apply(1'b1, ins(1, 1, 5'd5, 5'd2, 5'd0, 1, 0));
    tick();
    apply(1'b1, ins(1, 0, 5'd6, 5'd1, 5'd5, 0, 1));
    ex_redirect = 1'b1;
    #1;
    chk("rd_flush", {15'd0, flush_if_id}, 16'd1);
    chk("rd_stall_pc", {15'd0, stall_pc}, 16'd0);
    chk("rd_stall_if_id", {15'd0, stall_if_id}, 16'd0);
    tick();
    ex_redirect = 1'b0;
    chk("rd_flush_cnt", flush_cnt, 16'd1);
    chk("rd_stall_cnt", stall_cnt, 16'd1);
    chk("rd_ex_bubble", {15'd0, ex_load}, 16'd0);

    // Reset during a load-use stall.
    apply(1'b1, ins(1, 1, 5'd5, 5'd2, 5'd0, 1, 0));
    tick();
    apply(1'b1, ins(1, 0, 5'd6, 5'd5, 5'd1, 1, 1));
    #1;
    chk("rs_stall_before", {15'd0, stall_pc}, 16'd1);
    rst = 1'b1;
    #1;
    chk("rs_stall_in_rst", {15'd0, stall_pc}, 16'd0);
    chk("rs_stall_if_id_in_rst", {15'd0, stall_if_id}, 16'd0);
    tick();
    chk("rs_ex_load", {15'd0, ex_load}, 16'd0);
    chk("rs_mem_load", {15'd0, mem_load}, 16'd0);
    chk("rs_wb_rw", {15'd0, wb_reg_write}, 16'd0);
    chk("rs_stall_cnt", stall_cnt, 16'd0);
    chk("rs_flush_cnt", flush_cnt, 16'd0);
    rst = 1'b0;
    #1;
    chk("rs_clean_stall", {15'd0, stall_pc}, 16'd0);

    // Saturation: preload 16'hFFFE, then three load-use stalls.
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    chk("sat_preload", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, ins(1, 1, 5'd5, 5'd2, 5'd0, 1, 0));
      tick();
      apply(1'b1, ins(1, 0, 5'd6, 5'd5, 5'd1, 1, 1));
      #1;
      chk("sat_stall_pc", {15'd0, stall_pc}, 16'd1);
      tick();
      chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
